boot_seq_ctrl: RTL and testbench



---
 rtl/boot_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_boot_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_seq_ctrl.sv
// Load/run/dump sequencer for the core's instruction and data SRAMs over one valid/ready stream.
// Optional imem readback checksum after loading is enabled by defining BOOT_SEQ_VERIFY_EN.
module boot_seq_ctrl #(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, HDR, LOAD_I, VERIFY_RD, VERIFY_WT, LOAD_D,
    RUN, DUMP_RD, DUMP_WT, DUMP_OUT, DONE
  } state_t;

  localparam logic [15:0] IMAX = 16'(IMEM_DEPTH);
  localparam logic [15:0] DMAX = 16'(DMEM_DEPTH);

  state_t      state, nxt;
  logic [15:0] ic, dc, icnt, dcnt, wr_i, wr_d;
  logic [31:0] run_cnt;
  logic [63:0] data_q, out_q;
  logic        acc_q, wr_q, err_q, set_err, accept, hdr_ok;
  state_t      after_i;

  assign accept = s_valid && s_ready;
  assign hdr_ok = (s_data[15:0] <= IMAX) && (s_data[31:16] <= DMAX);
  assign wr_i   = icnt - 16'd1;
  assign wr_d   = dcnt - 16'd1;
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);
  assign err    = err_q;

`ifdef BOOT_SEQ_VERIFY_EN
  logic [31:0] chk, rb_chk, rb_next;
  assign rb_next = {rb_chk[30:0], rb_chk[31]} ^ rdata_ext;
  assign after_i = VERIFY_RD;
`else
  logic unused_ok;
  assign unused_ok = ^rdata_ext;
  assign after_i = (dc != 16'd0) ? LOAD_D : (run_cnt != 32'd0) ? RUN : DONE;
`endif

  always_comb begin
    nxt         = state;
    set_err     = 1'b0;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    addr_ext    = '0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    wdata_ext   = '0;
    addr_ext_2  = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = '0;
    cpu_enable  = 1'b0;
    case (state)
      IDLE: if (start) nxt = HDR;
      HDR: begin
        s_ready = !acc_q;
        if (accept) begin
          if (!hdr_ok) begin
            set_err = 1'b1;
            nxt     = IDLE;
          end else if (s_data[15:0] != 16'd0)  nxt = LOAD_I;
          else if (s_data[31:16] != 16'd0)     nxt = LOAD_D;
          else if (s_data[63:32] != 32'd0)     nxt = RUN;
          else                                 nxt = DONE;
        end
      end
      // Each beat is written the cycle after acceptance; the exit happens on the final write cycle.
      LOAD_I: begin
        s_ready = !acc_q;
        if (wr_q) begin
          wen_ext   = 1'b1;
          addr_ext  = {46'd0, wr_i, 2'b00};
          wdata_ext = data_q[31:0];
          if (icnt == ic) nxt = after_i;
        end
      end
`ifdef BOOT_SEQ_VERIFY_EN
      VERIFY_RD: begin
        ren_ext  = 1'b1;
        addr_ext = {46'd0, icnt, 2'b00};
        nxt      = VERIFY_WT;
      end
      VERIFY_WT: begin
        if (icnt == ic - 16'd1) begin
          if (rb_next != chk) begin
            set_err = 1'b1;
            nxt     = DONE;
          end else begin
            nxt = (dc != 16'd0) ? LOAD_D : (run_cnt != 32'd0) ? RUN : DONE;
          end
        end else begin
          nxt = VERIFY_RD;
        end
      end
`endif
      LOAD_D: begin
        s_ready = !acc_q;
        if (wr_q) begin
          wen_ext_2   = 1'b1;
          addr_ext_2  = {45'd0, wr_d, 3'b000};
          wdata_ext_2 = data_q;
          if (dcnt == dc) nxt = (run_cnt != 32'd0) ? RUN : DUMP_RD;
        end
      end
      RUN: begin
        cpu_enable = 1'b1;
        if (run_cnt == 32'd1) nxt = (dc != 16'd0) ? DUMP_RD : DONE;
      end
      DUMP_RD: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = {45'd0, dcnt, 3'b000};
        nxt        = DUMP_WT;
      end
      DUMP_WT: nxt = DUMP_OUT;
      DUMP_OUT: begin
        m_valid = 1'b1;
        m_data  = out_q;
        if (m_ready) nxt = (dcnt == dc - 16'd1) ? DONE : DUMP_RD;
      end
      DONE: if (start) nxt = HDR;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ic      <= '0;
      dc      <= '0;
      icnt    <= '0;
      dcnt    <= '0;
      run_cnt <= '0;
      data_q  <= '0;
      out_q   <= '0;
      acc_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_SEQ_VERIFY_EN
      chk     <= '0;
      rb_chk  <= '0;
`endif
    end else begin
      state <= nxt;
      acc_q <= accept;
      wr_q  <= accept && ((state == LOAD_I) || (state == LOAD_D));
      if (accept) data_q <= s_data;
      if (((state == IDLE) || (state == DONE)) && start) err_q <= 1'b0;
      else if (set_err)                                  err_q <= 1'b1;
      case (state)
        HDR: if (accept) begin
          ic      <= s_data[15:0];
          dc      <= s_data[31:16];
          run_cnt <= s_data[63:32];
          icnt    <= '0;
          dcnt    <= '0;
`ifdef BOOT_SEQ_VERIFY_EN
          chk     <= '0;
          rb_chk  <= '0;
`endif
        end
        LOAD_I: begin
          if (accept) begin
            icnt <= icnt + 16'd1;
`ifdef BOOT_SEQ_VERIFY_EN
            chk  <= {chk[30:0], chk[31]} ^ s_data[31:0];
`endif
          end
          if (nxt != LOAD_I) icnt <= '0;
        end
`ifdef BOOT_SEQ_VERIFY_EN
        VERIFY_WT: begin
          icnt   <= icnt + 16'd1;
          rb_chk <= rb_next;
        end
`endif
        LOAD_D: begin
          if (accept) dcnt <= dcnt + 16'd1;
          if (nxt != LOAD_D) dcnt <= '0;
        end
        RUN:      run_cnt <= run_cnt - 32'd1;
        DUMP_WT:  out_q <= rdata_ext_2;
        DUMP_OUT: if (m_ready) dcnt <= dcnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl with behavioural imem/dmem models and activity monitors.
module tb_boot_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, s_valid, m_ready;
  logic [63:0] s_data;
  logic        s_ready, m_valid;
  logic [63:0] m_data, addr_ext, addr_ext_2, wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = '0;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, done, err;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  boot_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err)
  );

  // Memory models and activity monitors
  logic [31:0] imem [0:127];
  logic [63:0] dmem [0:127];
  bit          corrupt = 1'b0;
  int n_wi = 0, n_wd = 0, n_en = 0, n_ren = 0, n_hs = 0, n_ovl = 0;
  int cyc = 0, last_w2 = 0, last_rise = 0, last_r2 = 0, last_mv = 0;
  logic en_prev = 1'b0, mv_prev = 1'b0;
  logic [63:0] wi_addr[$], wd_addr[$], hs_data[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wen_ext) begin
      imem[addr_ext[8:2]] <= wdata_ext;
      n_wi <= n_wi + 1;
      wi_addr.push_back(addr_ext);
    end
    if (wen_ext_2) begin
      dmem[addr_ext_2[9:3]] <= wdata_ext_2;
      n_wd <= n_wd + 1;
      wd_addr.push_back(addr_ext_2);
      last_w2 <= cyc;
    end
    if (ren_ext)
      rdata_ext <= imem[addr_ext[8:2]] ^ ((corrupt && addr_ext[8:2] == 7'd1) ? 32'h1 : 32'h0);
    if (ren_ext_2) begin
      rdata_ext_2 <= dmem[addr_ext_2[9:3]];
      n_ren <= n_ren + 1;
      last_r2 <= cyc;
    end
    if (cpu_enable) n_en <= n_en + 1;
    if (cpu_enable && !en_prev) last_rise <= cyc;
    en_prev <= cpu_enable;
    if ((cpu_enable && (wen_ext || wen_ext_2 || ren_ext || ren_ext_2)) ||
        ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)))
      n_ovl <= n_ovl + 1;
    if (m_valid && m_ready) begin
      n_hs <= n_hs + 1;
      hs_data.push_back(m_data);
    end
    if (m_valid && !mv_prev) last_mv <= cyc;
    mv_prev <= m_valid;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int ic, input int dc, input int rc);
    return {32'(rc), 16'(dc), 16'(ic)};
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input string tag, input logic [63:0] v);
    int n = 0;
    s_valid = 1'b1;
    s_data  = v;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  initial begin
    int b_wi, b_wd, b_en, b_ren, b_hs, n;
    logic [63:0] d0;
    bit stable;

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_flags", {54'd0, s_ready, m_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                      cpu_enable, busy, done, err}, 64'd0);
    chk("rst_addr", addr_ext | addr_ext_2 | m_data | wdata_ext_2, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: basic load / run / dump
    b_wi = n_wi; b_wd = n_wd; b_en = n_en; b_hs = n_hs;
    do_start();
    chk("t1_hdr_ready", {62'd0, s_ready, busy}, 64'd3);
    send("t1_hdr", hdr(2, 2, 10));
    send("t1_i0", 64'h0000_0000_0000_0013);
    send("t1_i1", 64'hFFFF_FFFF_00A0_0093);
    send("t1_d0", 64'h5);
    send("t1_d1", 64'h7);
    wait_done("t1_done");
    chk("t1_n_wi", 64'(n_wi - b_wi), 64'd2);
    chk("t1_wi_a0", wi_addr[b_wi], 64'd0);
    chk("t1_wi_a1", wi_addr[b_wi + 1], 64'd4);
    chk("t1_imem1", {32'd0, imem[1]}, 64'h00A0_0093);
    chk("t1_n_wd", 64'(n_wd - b_wd), 64'd2);
    chk("t1_wd_a0", wd_addr[b_wd], 64'd0);
    chk("t1_wd_a1", wd_addr[b_wd + 1], 64'd8);
    chk("t1_en_cycles", 64'(n_en - b_en), 64'd10);
    chk("t1_en_rise", 64'(last_rise - last_w2), 64'd1);
    chk("t1_mv_lat", 64'(last_mv - last_r2), 64'd2);
    chk("t1_n_hs", 64'(n_hs - b_hs), 64'd2);
    chk("t1_dump0", hs_data[b_hs], 64'h5);
    chk("t1_dump1", hs_data[b_hs + 1], 64'h7);
    chk("t1_flags", {61'd0, busy, err, done}, 64'd1);

    // Test 2: oversize header rejected
    b_wi = n_wi; b_wd = n_wd; b_en = n_en;
    do_start();
    send("t2_hdr", hdr(129, 1, 5));
    chk("t2_flags", {60'd0, err, done, busy, s_ready}, 64'h8);
    repeat (4) @(negedge clk);
    chk("t2_no_act", 64'((n_wi - b_wi) + (n_wd - b_wd) + (n_en - b_en)), 64'd0);

    // Test 3: all-zero header goes straight to DONE
    b_wi = n_wi; b_wd = n_wd; b_en = n_en; b_ren = n_ren; b_hs = n_hs;
    do_start();
    chk("t3_err_clr", {63'd0, err}, 64'd0);
    send("t3_hdr", hdr(0, 0, 0));
    chk("t3_done", {63'd0, done}, 64'd1);
    chk("t3_no_act", 64'((n_wi - b_wi) + (n_wd - b_wd) + (n_en - b_en) +
                         (n_ren - b_ren) + (n_hs - b_hs)), 64'd0);

    // Test 4: dump backpressure
    m_ready = 1'b0;
    b_hs = n_hs;
    do_start();
    send("t4_hdr", hdr(1, 3, 2));
    send("t4_i0", 64'h99);
    send("t4_d0", 64'h11);
    send("t4_d1", 64'h22);
    send("t4_d2", 64'h33);
    for (int w = 0; w < 3; w++) begin
      n = 0;
      while (!m_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      d0 = m_data;
      stable = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (!m_valid || m_data !== d0) stable = 1'b0;
      end
      chk("t4_stable", {63'd0, stable}, 64'd1);
      chk("t4_data", d0, 64'(17 * (w + 1)));
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    wait_done("t4_done");
    chk("t4_n_hs", 64'(n_hs - b_hs), 64'd3);
    m_ready = 1'b1;

    // Test 5: reset in the middle of RUN, then a clean rerun
    b_en = n_en;
    do_start();
    send("t5_hdr", hdr(1, 1, 100));
    send("t5_i0", 64'h13);
    send("t5_d0", 64'hAB);
    n = 0;
    while (!cpu_enable && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_run", {63'd0, cpu_enable}, 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_flags", {54'd0, s_ready, m_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                         cpu_enable, busy, done, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_en_cycles", 64'(n_en - b_en), 64'd4);
    b_en = n_en; b_hs = n_hs;
    do_start();
    send("t5_hdr2", hdr(1, 1, 3));
    send("t5_i0b", 64'h13);
    send("t5_d0b", 64'hCD);
    wait_done("t5_done");
    chk("t5_en2", 64'(n_en - b_en), 64'd3);
    chk("t5_dump", hs_data[b_hs], 64'hCD);
    chk("t5_err", {63'd0, err}, 64'd0);

`ifdef BOOT_SEQ_VERIFY_EN
    // Test 6: corrupted imem readback
    b_wd = n_wd; b_en = n_en;
    corrupt = 1'b1;
    do_start();
    send("t6_hdr", hdr(2, 1, 5));
    send("t6_i0", 64'h13);
    send("t6_i1", 64'h00A0_0093);
    wait_done("t6_done");
    chk("t6_err", {63'd0, err}, 64'd1);
    chk("t6_no_act", 64'((n_wd - b_wd) + (n_en - b_en)), 64'd0);
    corrupt = 1'b0;
`endif

    chk("overlap", 64'(n_ovl), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
